// File: rtl/cmp_arb_pkg.sv
// cmp_arb_pkg: shared types, default sizes and round-robin pick for the comparator arbiter
package cmp_arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 3;
  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] w;
    logic found;
    int idx;
    w = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && i < n && req[idx]) begin
        w = 3'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction
endpackage

// File: rtl/cmp_rr_arbiter_cmp_unit.sv
// cmp_unit: registered unsigned magnitude comparator, loads res when en is high
module cmp_unit
  import cmp_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);
  always_ff @(posedge clk) begin
    if (rst) res <= '0;
    else if (en) res <= {a > b, a == b, a < b};
  end
endmodule

// File: rtl/cmp_rr_arbiter.sv
// cmp_rr_arbiter: round-robin sharing of one registered comparator among N_REQ req/ack requesters
module cmp_rr_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       ack,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_gt,
  output logic                   rsp_eq,
  output logic                   rsp_lt,
  output logic                   busy
);
  state_t state;
  logic [ID_W-1:0] rr_ptr, cap_id, win;
  logic [WIDTH-1:0] cap_a, cap_b;
  cmp_res_t res;
  assign win = ID_W'(rr_pick(8'(req), 3'(rr_ptr), N_REQ));
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      ack       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      cap_id    <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
    end else if (state == CMP) begin
      state     <= RESP;
      ack       <= '0;
      rsp_valid <= 1'b1;
      rsp_id    <= cap_id;
    end else begin
      rsp_valid <= 1'b0;
      ack       <= '0;
      state     <= IDLE;
      if (|req) begin
        state  <= CMP;
        ack    <= N_REQ'(1) << win;
        rr_ptr <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
        cap_id <= win;
        cap_a  <= a_in[win*WIDTH +: WIDTH];
        cap_b  <= b_in[win*WIDTH +: WIDTH];
      end
    end
  end
  cmp_unit #(.WIDTH(WIDTH)) u_cmp (
    .clk(clk),
    .rst(rst),
    .en (state == CMP),
    .a  (cap_a),
    .b  (cap_b),
    .res(res)
  );
  assign rsp_gt = res.gt;
  assign rsp_eq = res.eq;
  assign rsp_lt = res.lt;
  assign busy   = state != IDLE;
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> $onehot({rsp_gt, rsp_eq, rsp_lt}));
  a_ack_gap:    assert property (@(posedge clk) disable iff (rst) |ack |=> ack == '0);
endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// tb_cmp_rr_arbiter: directed and randomized checks of cmp_rr_arbiter against a cycle model
module tb_cmp_rr_arbiter;
  localparam int N = 4;
  localparam int W = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] a_in = '0, b_in = '0;
  logic [N-1:0] ack;
  logic rsp_valid, rsp_gt, rsp_eq, rsp_lt, busy;
  logic [1:0] rsp_id;
  int n_checks = 0, n_fail = 0;
  cmp_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq),
    .rsp_lt(rsp_lt), .busy(busy)
  );
  always #5 clk = ~clk;
  int phase = 0, ptr = 0, c_a = 0, c_b = 0, c_id = 0, win;
  logic [N-1:0] m_ack = '0;
  logic m_rv = 1'b0;
  logic [1:0] m_id = '0;
  logic [2:0] m_res = '0;
  bit started = 0;
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      phase = 0; ptr = 0; m_ack = '0; m_rv = 0; m_id = '0; m_res = '0;
    end else if (phase == 1) begin
      m_rv = 1; m_ack = '0; m_id = 2'(c_id);
      m_res = {c_a > c_b, c_a == c_b, c_a < c_b};
      phase = 2;
    end else begin
      m_rv = 0; m_ack = '0; phase = 0;
      if (req != 0) begin
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && req[(ptr + k) % N]) win = (ptr + k) % N;
        m_ack = N'(1 << win);
        ptr = (win + 1) % N;
        c_a = int'((a_in >> (win * W)) & 7);
        c_b = int'((b_in >> (win * W)) & 7);
        c_id = win;
        phase = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      n_checks++;
      if ({ack, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy} !==
          {m_ack, m_rv, m_id, m_res, phase != 0}) begin
        n_fail++;
        $display("FAIL model t=%0t: ack=%b rv=%b id=%0d gel=%b busy=%b, required ack=%b rv=%b id=%0d gel=%b busy=%b",
                 $time, ack, rsp_valid, rsp_id, {rsp_gt, rsp_eq, rsp_lt}, busy,
                 m_ack, m_rv, m_id, m_res, phase != 0);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input int i, input int a, input int b);
    a_in[i*W +: W] = 3'(a);
    b_in[i*W +: W] = 3'(b);
  endtask
  task automatic do_reset();
    rst = 1; req = '0;
    tick(); tick();
    rst = 0;
  endtask
  logic [2:0] exp_gel [4];
  initial begin
    rst = 1; req = 4'b1111;
    tick();
    chk("rst ack", 32'(ack), 0); chk("rst rv", 32'(rsp_valid), 0); chk("rst busy", 32'(busy), 0);
    tick();
    chk("rst ack2", 32'(ack), 0); chk("rst rv2", 32'(rsp_valid), 0); chk("rst busy2", 32'(busy), 0);
    rst = 0;
    tick();
    chk("post-rst ack", 32'(ack), 32'b0001);
    req = '0;
    do_reset();
    req = 4'b0001; set_op(0, 5, 3);
    tick();
    chk("single ack", 32'(ack), 32'b0001); chk("single busy", 32'(busy), 1);
    req = '0;
    tick();
    chk("single rv", 32'(rsp_valid), 1); chk("single id", 32'(rsp_id), 0);
    chk("single gel", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'b100); chk("single ack off", 32'(ack), 0);
    tick();
    chk("single busy drop", 32'(busy), 0); chk("single rv drop", 32'(rsp_valid), 0);
    do_reset();
    set_op(0, 3, 3); set_op(1, 1, 6); set_op(2, 7, 0); set_op(3, 2, 2);
    exp_gel[0] = 3'b010; exp_gel[1] = 3'b001; exp_gel[2] = 3'b100; exp_gel[3] = 3'b010;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("full ack%0d", i), 32'(ack), 32'(1 << i));
      tick();
      chk($sformatf("full rv%0d", i), 32'(rsp_valid), 1);
      chk($sformatf("full id%0d", i), 32'(rsp_id), 32'(i));
      chk($sformatf("full gel%0d", i), 32'({rsp_gt, rsp_eq, rsp_lt}), 32'(exp_gel[i]));
    end
    tick();
    chk("full wrap ack", 32'(ack), 32'b0001);
    req = '0;
    do_reset();
    req = 4'b1000;
    tick();
    chk("wrap ack3", 32'(ack), 32'b1000);
    req = 4'b1001;
    tick(); tick();
    chk("wrap ack0", 32'(ack), 32'b0001);
    tick(); tick();
    chk("wrap ack3 again", 32'(ack), 32'b1000);
    req = '0;
    do_reset();
    req = 4'b0100; set_op(2, 4, 1);
    tick();
    chk("midrst ack", 32'(ack), 32'b0100);
    rst = 1; req = '0;
    tick();
    chk("midrst rv", 32'(rsp_valid), 0); chk("midrst ack off", 32'(ack), 0);
    rst = 0; req = 4'b0110;
    tick();
    chk("midrst regrant", 32'(ack), 32'b0010);
    req = '0;
    tick();
    chk("midrst rsp id", 32'(rsp_id), 1);
    tick();
    do_reset();
    exp_gel[0] = 3'b100; exp_gel[1] = 3'b001; exp_gel[2] = 3'b010; exp_gel[3] = 3'b010;
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_op(0, 7, 0);
        1: set_op(0, 0, 7);
        2: set_op(0, 0, 0);
        default: set_op(0, 7, 7);
      endcase
      tick();
      chk($sformatf("bnd ack%0d", i), 32'(ack), 32'b0001);
      chk($sformatf("bnd rv low%0d", i), 32'(rsp_valid), 0);
      tick();
      chk($sformatf("bnd rv%0d", i), 32'(rsp_valid), 1);
      chk($sformatf("bnd gel%0d", i), 32'({rsp_gt, rsp_eq, rsp_lt}), 32'(exp_gel[i]));
    end
    req = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      req = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
      a_in = 12'($urandom);
      b_in = ($urandom_range(0, 3) == 0) ? a_in : 12'($urandom);
      tick();
    end
    rst = 0; req = '0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
